alu_issue_ctrl: RTL and testbench

Initiator-side controller for the two-phase, trigger-driven ALU. It accepts one ARM data-processing instruction word per handshake and decodes it. It reads Rn/Rm from the register file, drives the ALU operand/opcode/shift inputs and toggles the ALU trigger. After a settle delay it captures result/w/flags and performs register writeback plus the CPSR NZCV update. Sits between instruction fetch and the ALU/register file; single-issue, one instruction in flight.

---
 rtl/alu_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the trigger-driven ALU: decode, operand fetch, trigger, settle, writeback + NZCV.
// Latency: rf_we in cycle 3+SETTLE_CYCLES after the handshake edge; a skipped instruction re-readies after 2 cycles.
// Backpressure: instr_ready only in IDLE, one instruction in flight. Define COND_EXEC_EN to enable condition codes and SKIP.
module alu_issue_ctrl #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] CPSR_RESET    = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        instr_err,
    output logic        cond_skip,
    output logic        busy,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic [31:0] alu_operand1,
    output logic [31:0] alu_operand2,
    output logic [3:0]  alu_opcode,
    output logic [4:0]  alu_shift_amount,
    output logic [1:0]  alu_shift_type,
    output logic [3:0]  alu_dest_reg,
    output logic        alu_trigger,
    input  logic [31:0] alu_result,
    input  logic        alu_w,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  cpsr_nzcv
);

`ifdef COND_EXEC_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_WB, S_SKIP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_WB} state_t;
`endif

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic [3:0]  cnt_q;

    logic        illegal;
    logic        cond_ok;
    logic        v_op;
    logic [31:0] op2_d;
    logic [1:0]  type_d;
    logic [4:0]  amt_d;

`ifdef COND_EXEC_EN
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'ha:    cond_pass = (n == v);
            4'hb:    cond_pass = (n != v);
            4'hc:    cond_pass = !z && (n == v);
            4'hd:    cond_pass = z || (n != v);
            4'he:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign cond_ok   = cond_pass(instr_q[31:28], cpsr_nzcv);
    assign cond_skip = (state_q == S_SKIP);
`else
    logic unused_cond;
    assign unused_cond = ^instr_q[31:28];
    assign cond_ok     = 1'b1;
    assign cond_skip   = 1'b0;
`endif

    assign rf_raddr_a = instr_q[19:16];
    assign rf_raddr_b = instr_q[3:0];
    assign illegal    = (instr_q[27:26] != 2'b00) || (!instr_q[25] && instr_q[4]);
    assign v_op       = (alu_opcode == 4'b0100) || (alu_opcode == 4'b0101) || (alu_opcode == 4'b1011);

    // A zero shift/rotate amount always degenerates to "no shift" (no RRX support).
    always_comb begin
        op2_d  = rf_rdata_b;
        type_d = 2'b00;
        amt_d  = 5'd0;
        if (instr_q[25]) begin
            op2_d = {24'b0, instr_q[7:0]};
            if (instr_q[11:8] != 4'd0) begin
                type_d = 2'b11;
                amt_d  = {instr_q[11:8], 1'b0};
            end
        end else if (instr_q[11:7] != 5'd0) begin
            type_d = instr_q[6:5];
            amt_d  = instr_q[11:7];
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        instr_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (illegal) begin
                    instr_err = 1'b1;
                    state_d   = S_IDLE;
`ifdef COND_EXEC_EN
                end else if (!cond_ok) begin
                    state_d = S_SKIP;
`endif
                end else begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: state_d = S_WAIT;
            // The first WAIT cycle is the trigger edge itself; SETTLE_CYCLES more follow.
            S_WAIT: if (cnt_q == SETTLE_LAST) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign rf_we    = (state_q == S_WB) && alu_w;
    assign rf_waddr = (state_q == S_WB) ? alu_dest_reg : 4'd0;
    assign rf_wdata = (state_q == S_WB) ? alu_result : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            instr_q          <= '0;
            cnt_q            <= '0;
            alu_operand1     <= '0;
            alu_operand2     <= '0;
            alu_opcode       <= '0;
            alu_shift_amount <= '0;
            alu_shift_type   <= '0;
            alu_dest_reg     <= '0;
            alu_trigger      <= 1'b0;
            cpsr_nzcv        <= CPSR_RESET;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && instr_valid) instr_q <= instr;
            if (state_q == S_LOAD && !illegal && cond_ok) begin
                alu_operand1     <= rf_rdata_a;
                alu_operand2     <= op2_d;
                alu_opcode       <= instr_q[24:21];
                alu_shift_amount <= amt_d;
                alu_shift_type   <= type_d;
                alu_dest_reg     <= instr_q[15:12];
            end
            if (state_q == S_FIRE) begin
                alu_trigger <= ~alu_trigger;
                cnt_q       <= '0;
            end
            if (state_q == S_WAIT) cnt_q <= cnt_q + 4'd1;
            if (state_q == S_WB && instr_q[20]) begin
                cpsr_nzcv[3:1] <= {alu_n, alu_z, alu_c};
                if (v_op) cpsr_nzcv[0] <= alu_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural register file and ALU responder around the controller.
module tb_alu_issue_ctrl;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready, instr_err, cond_skip, busy;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic [31:0] alu_operand1, alu_operand2;
    logic [3:0]  alu_opcode, alu_dest_reg;
    logic [4:0]  alu_shift_amount;
    logic [1:0]  alu_shift_type;
    logic        alu_trigger;
    logic [31:0] alu_result;
    logic        alu_w, alu_n, alu_z, alu_c, alu_v;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  cpsr_nzcv;

    int tests = 0;
    int fails = 0;
    int tog_cnt = 0;
    logic trig_q = 1'b0;
    logic [3:0]  last_wa;
    logic [31:0] last_wd;
    logic [31:0] rf [16];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.SETTLE_CYCLES(S), .CPSR_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .instr_err(instr_err), .cond_skip(cond_skip), .busy(busy),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_opcode(alu_opcode),
        .alu_shift_amount(alu_shift_amount), .alu_shift_type(alu_shift_type), .alu_dest_reg(alu_dest_reg),
        .alu_trigger(alu_trigger), .alu_result(alu_result), .alu_w(alu_w),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cpsr_nzcv(cpsr_nzcv)
    );

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

    always @(negedge clk) begin
        if (alu_trigger !== trig_q) tog_cnt = tog_cnt + 1;
        trig_q = alu_trigger;
    end

    // Behavioural ALU: shifter plus the handful of opcodes the directed steps use.
    logic [31:0] sh;
    logic [32:0] sum;
    always_comb begin
        sh = alu_operand2;
        case (alu_shift_type)
            2'b00: sh = alu_operand2 << alu_shift_amount;
            2'b01: sh = alu_operand2 >> alu_shift_amount;
            2'b10: sh = 32'($signed(alu_operand2) >>> alu_shift_amount);
            default: sh = (alu_operand2 >> alu_shift_amount) | (alu_operand2 << (6'd32 - {1'b0, alu_shift_amount}));
        endcase
        sum = 33'd0;
        alu_result = 32'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_opcode)
            4'b0100: begin
                sum = {1'b0, alu_operand1} + {1'b0, sh};
                alu_result = sum[31:0];
                alu_c = sum[32];
                alu_v = (alu_operand1[31] == sh[31]) && (alu_result[31] != alu_operand1[31]);
            end
            4'b0010, 4'b1010: begin
                sum = {1'b0, alu_operand1} - {1'b0, sh};
                alu_result = sum[31:0];
                alu_c = ~sum[32];
                alu_v = (alu_operand1[31] != sh[31]) && (alu_result[31] != alu_operand1[31]);
            end
            4'b1101: alu_result = sh;
            default: alu_result = 32'd0;
        endcase
        alu_w = (alu_opcode[3:2] != 2'b10);
        alu_n = alu_result[31];
        alu_z = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle c is the state following the c-th edge after the handshake edge.
    task automatic run(input logic [31:0] w, output int we_cyc, output int rdy_cyc,
                       output int err_cyc, output int skip_cyc, output int toggles);
        int t0;
        we_cyc = -1; rdy_cyc = -1; err_cyc = -1; skip_cyc = -1;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        t0 = tog_cnt;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (rf_we) begin we_cyc = c; last_wa = rf_waddr; last_wd = rf_wdata; end
            if (instr_err) err_cyc = c;
            if (cond_skip) skip_cyc = c;
            if (instr_ready && c > 0) begin rdy_cyc = c; break; end
            @(posedge clk); #1;
        end
        @(negedge clk);
        toggles = tog_cnt - t0;
    endtask

    initial begin
        int we_c, rdy_c, err_c, skip_c, tg;
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        rf[0] = 32'd5;
        rf[1] = 32'd7;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_trigger", {31'd0, alu_trigger}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_cpsr", {28'd0, cpsr_nzcv}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ADD r2,r0,r1
        run(32'hE0802001, we_c, rdy_c, err_c, skip_c, tg);
        chk("add_we_cycle", we_c, 3 + S);
        chk("add_ready_cycle", rdy_c, 4 + S);
        chk("add_waddr", {28'd0, last_wa}, 32'd2);
        chk("add_wdata", last_wd, 32'd12);
        chk("add_op1", alu_operand1, 32'd5);
        chk("add_op2", alu_operand2, 32'd7);
        chk("add_toggles", tg, 1);
        chk("add_cpsr", {28'd0, cpsr_nzcv}, 32'h0);

        // SUBS r3,r0,r0: N=0 Z=1 C=1, V held at 0
        run(32'hE0503000, we_c, rdy_c, err_c, skip_c, tg);
        chk("subs_wdata", last_wd, 32'd0);
        chk("subs_waddr", {28'd0, last_wa}, 32'd3);
        chk("subs_cpsr", {28'd0, cpsr_nzcv}, 32'h6);

        // MOVEQ r4,#0xFF with Z=1
        run(32'h03A040FF, we_c, rdy_c, err_c, skip_c, tg);
        chk("moveq_wdata", last_wd, 32'h000000FF);
        chk("moveq_waddr", {28'd0, last_wa}, 32'd4);
        chk("moveq_type", {30'd0, alu_shift_type}, 32'd0);
        chk("moveq_cpsr", {28'd0, cpsr_nzcv}, 32'h6);

        // CMP r0,r1: no writeback, N=1 Z=0 C=0, V held
        run(32'hE1500001, we_c, rdy_c, err_c, skip_c, tg);
        chk("cmp_we_cycle", we_c, -1);
        chk("cmp_ready_cycle", rdy_c, 4 + S);
        chk("cmp_cpsr", {28'd0, cpsr_nzcv}, 32'h8);

        // MOVEQ again with Z=0
        rf[4] = 32'd0;
        run(32'h03A040FF, we_c, rdy_c, err_c, skip_c, tg);
`ifdef COND_EXEC_EN
        chk("skip_pulse_cycle", skip_c, 1);
        chk("skip_ready_cycle", rdy_c, 2);
        chk("skip_toggles", tg, 0);
        chk("skip_we_cycle", we_c, -1);
        chk("skip_r4", rf[4], 32'd0);
`else
        chk("noskip_pulse", skip_c, -1);
        chk("noskip_we_cycle", we_c, 3 + S);
        chk("noskip_toggles", tg, 1);
        chk("noskip_wdata", last_wd, 32'h000000FF);
`endif

        // MOV r5,#0xFF ror 8
        run(32'hE3A054FF, we_c, rdy_c, err_c, skip_c, tg);
        chk("ror_type", {30'd0, alu_shift_type}, 32'd3);
        chk("ror_amount", {27'd0, alu_shift_amount}, 32'd8);
        chk("ror_op2", alu_operand2, 32'h000000FF);
        chk("ror_wdata", last_wd, 32'hFF000000);
        chk("ror_waddr", {28'd0, last_wa}, 32'd5);
        chk("ror_cpsr", {28'd0, cpsr_nzcv}, 32'h8);

        // Register-specified shift is illegal
        run(32'hE0802011, we_c, rdy_c, err_c, skip_c, tg);
        chk("illegal_err_cycle", err_c, 0);
        chk("illegal_ready_cycle", rdy_c, 1);
        chk("illegal_toggles", tg, 0);
        chk("illegal_we_cycle", we_c, -1);

        // Reset taken in WAIT
        @(negedge clk);
        instr = 32'hE0802001;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("midrst_cpsr", {28'd0, cpsr_nzcv}, 32'h0);
        chk("midrst_trigger", {31'd0, alu_trigger}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst_rf_we", {31'd0, rf_we}, 32'd0);

        // Recovery after reset
        run(32'hE0802001, we_c, rdy_c, err_c, skip_c, tg);
        chk("recover_we_cycle", we_c, 3 + S);
        chk("recover_wdata", last_wd, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (tests=%0d failed=%0d)", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
